mem_resp_stage: RTL and testbench
=================================

MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

Interface
REQ-001 Parameter DATA_W, default 32, meaning data-path and SRAM read-data width; legal values are 32 and 64.
REQ-002 Parameter MAX_OUTST, default 2, meaning the maximum number of in-flight load responses that may be discarded after flushes.
REQ-003 Derived constant OFF_W = log2(DATA_W/8), meaning the byte-offset width; derived constant BE_W = DATA_W/8, meaning the byte-enable width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 es_to_ms_valid  in  1  EX stage offers an instruction.
REQ-007 ms_allowin  out  1  this stage accepts an instruction this cycle.
REQ-008 es_is_load  in  1  the offered instruction has issued a data-SRAM read request.
REQ-009 es_gr_we  in  1  register write enable.
REQ-010 es_dest  in  5  destination register.
REQ-011 es_alu_result  in  DATA_W  ALU result, or the address for loads.
REQ-012 es_pc  in  32  instruction PC.
REQ-013 es_ld_width  in  2  load width: 01 byte, 10 half, 11 word, 00 doubleword (DATA_W=64 only).
REQ-014 es_ld_sign  in  1  sign-extend the loaded value.
REQ-015 es_ld_lr  in  2  bit1 is left-partial (lwl-type), bit0 is right-partial (lwr-type).
REQ-016 es_ld_off  in  OFF_W  byte offset of the load address.
REQ-017 data_sram_data_ok  in  1  read response valid; responses arrive in request order.
REQ-018 data_sram_rdata  in  DATA_W  read response data.
REQ-019 flush  in  1  exception or eret flush from CP0.
REQ-020 ws_allowin  in  1  WB stage accepts an instruction.
REQ-021 ms_to_ws_valid  out  1  result valid toward WB.
REQ-022 ms_reg_we  out  BE_W  per-byte register write enable.
REQ-023 ms_dest  out  5  destination register.
REQ-024 ms_final_result  out  DATA_W  write-back data.
REQ-025 ms_pc  out  32  instruction PC.
REQ-026 ms_load_wait  out  1  a valid load is awaiting data; the decode stage uses it to block forwarding.

Function
REQ-027 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin); the input fields SHALL be latched when es_to_ms_valid && ms_allowin.
REQ-028 ms_ready_go SHALL be 1 for a non-load, and 1 for a load when buf_valid is set or when data_sram_data_ok is high with discard_cnt==0.
REQ-029 A non-load SHALL add zero latency; a load SHALL present its result in the same cycle its own data_ok arrives.
REQ-030 A load whose data_ok arrives while ws_allowin=0 SHALL store the data in rdata_buf and set buf_valid; buf_valid SHALL clear when the instruction leaves this stage.
REQ-031 ms_load_wait SHALL equal ms_valid && is_load && !ms_ready_go.
REQ-032 A flush SHALL clear ms_valid and buf_valid on the following edge.
REQ-033 A flush that occurs while a valid load is awaiting its data SHALL increment discard_cnt.
REQ-034 If a flush and that load's own data_ok occur in the same cycle, the data SHALL be dropped and discard_cnt SHALL NOT increment.
REQ-035 While discard_cnt>0, each data_ok SHALL decrement discard_cnt and its data SHALL be dropped, even if a new load is resident in this stage.
REQ-036 If an increment and a decrement of discard_cnt coincide, discard_cnt SHALL be unchanged.
REQ-037 discard_cnt SHALL saturate at MAX_OUTST; an increment attempted at MAX_OUTST is a protocol error and SHALL be flagged by a simulation assertion.
REQ-038 Load extraction: byte and half SHALL select the lane indexed by es_ld_off (half lane = off>>1, word lane = off>>2 when DATA_W=64), then zero- or sign-extend to DATA_W.
REQ-039 Load extraction: left-partial SHALL take {rdata,rdata} shifted so that byte off lands in the MSB; right-partial SHALL take {rdata,rdata} shifted right by off bytes.
REQ-040 ms_reg_we SHALL be all-ones when lr==00 && gr_we; for left-partial, bytes BE_W-1 down to BE_W-1-off SHALL be set; for right-partial, bytes BE_W-1-off down to 0 SHALL be set; all bits SHALL be 0 when !ms_valid.
REQ-041 ms_final_result SHALL be the extracted load data for loads and alu_result otherwise.

Reset
REQ-042 Asserting resetn low SHALL immediately clear ms_valid, buf_valid and discard_cnt, forcing ms_to_ws_valid=0, ms_load_wait=0, ms_reg_we=0 and ms_allowin=1.
REQ-043 The data registers (alu_result, pc, dest, rdata_buf) SHALL NOT require reset.
REQ-044 A response arriving after reset release for a pre-reset request is outside the specified behaviour.

Structure
REQ-045 The load-width codes, the lr bit positions, and the DATA_W legality check SHALL be placed in the shared mycpu header/package.
REQ-046 The extraction and byte-enable logic SHALL be one combinational sub-module named load_align, parametrised by DATA_W.

Verification
REQ-047 Scenario: lb at off=3, rdata=0x80FF_0000, sign=1 -> result 0xFFFF_FF80, reg_we=1111.
REQ-048 Scenario: lwl at off=1, rdata=0x4433_2211 -> reg_we=1100, result[31:16]=0x2211.
REQ-049 Scenario: load with data_ok while ws_allowin=0 for 3 cycles -> buf_valid=1 and data held; delivered exactly once when ws_allowin rises.
REQ-050 Scenario: flush while a load waits, then a new load enters, then two data_ok pulses (0xDEAD, 0x1234) -> 0xDEAD dropped, discard_cnt 1->0, new load result 0x1234.
REQ-051 Scenario: flush coincident with the waiting load's data_ok -> discard_cnt stays 0, and the next response goes to the next load.
REQ-052 Scenario: DATA_W=64, lh at off=6, rdata[63:48]=0x8001, sign=0 -> result 0x0000_0000_0000_8001.

Source files
------------

// File: rtl/mem_resp_stage_pkg.sv
// Shared load-path definitions: load-width codes, partial-load bit positions
// and the data-path width legality check.
package mem_resp_stage_pkg;

  typedef enum logic [1:0] {
    LD_DWORD = 2'b00,
    LD_BYTE  = 2'b01,
    LD_HALF  = 2'b10,
    LD_WORD  = 2'b11
  } ld_width_e;

  localparam int unsigned LR_LEFT_BIT  = 1;
  localparam int unsigned LR_RIGHT_BIT = 0;

  function automatic bit data_w_legal(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Combinational load-data extraction and per-byte register write enables.
module load_align
  import mem_resp_stage_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8),
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        ld_width,
  input  logic              ld_sign,
  input  logic [1:0]        ld_lr,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic              gr_we,
  output logic [DATA_W-1:0] ld_result,
  output logic [BE_W-1:0]   reg_we
);

  localparam int unsigned SH_W = OFF_W + 3;

  logic [2*DATA_W-1:0] dbl;
  logic [SH_W-1:0]     b_sh;
  logic [SH_W-1:0]     h_sh;
  logic [SH_W-1:0]     w_sh;
  logic [SH_W-1:0]     l_sh;
  logic [7:0]          b_lane;
  logic [15:0]         h_lane;
  logic [31:0]         w_lane;
  logic [DATA_W-1:0]   left_data;
  logic [DATA_W-1:0]   right_data;
  logic [BE_W-1:0]     ones;
  ld_width_e           width;

  always_comb begin
    width  = ld_width_e'(ld_width);
    ones   = '1;
    b_sh   = {ld_off, 3'b000};
    h_sh   = SH_W'({ld_off >> 1, 4'b0000});
    w_sh   = SH_W'({ld_off >> 2, 5'b00000});
    // byte (BE_W-1-off) == ~off, so this left shift lands byte off in the MSB
    l_sh   = {~ld_off, 3'b000};
    b_lane = 8'(rdata >> b_sh);
    h_lane = 16'(rdata >> h_sh);
    w_lane = 32'(rdata >> w_sh);
    dbl        = {rdata, rdata};
    left_data  = DATA_W'((dbl << l_sh) >> DATA_W);
    right_data = DATA_W'(dbl >> b_sh);

    ld_result = rdata;
    reg_we    = gr_we ? ones : '0;
    if (ld_lr[LR_LEFT_BIT]) begin
      ld_result = left_data;
      reg_we    = gr_we ? (ones << ~ld_off) : '0;
    end else if (ld_lr[LR_RIGHT_BIT]) begin
      ld_result = right_data;
      reg_we    = gr_we ? (ones >> ld_off) : '0;
    end else begin
      case (width)
        LD_BYTE: ld_result = ld_sign ? DATA_W'(signed'(b_lane)) : DATA_W'(b_lane);
        LD_HALF: ld_result = ld_sign ? DATA_W'(signed'(h_lane)) : DATA_W'(h_lane);
        LD_WORD: ld_result = ld_sign ? DATA_W'(signed'(w_lane)) : DATA_W'(w_lane);
        default: ld_result = rdata;
      endcase
    end
  end

endmodule

// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage: waits for in-order SRAM read data, buffers it
// under back-pressure and discards responses belonging to flushed loads.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned MAX_OUTST = 2,
  localparam int unsigned OFF_W     = $clog2(DATA_W / 8),
  localparam int unsigned BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic              es_is_load,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [31:0]       es_pc,
  input  logic [1:0]        es_ld_width,
  input  logic              es_ld_sign,
  input  logic [1:0]        es_ld_lr,
  input  logic [OFF_W-1:0]  es_ld_off,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [BE_W-1:0]   ms_reg_we,
  output logic [4:0]        ms_dest,
  output logic [DATA_W-1:0] ms_final_result,
  output logic [31:0]       ms_pc,
  output logic              ms_load_wait
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("mem_resp_stage: DATA_W must be 32 or 64");
  end

  logic              ms_valid_q, ms_valid_d;
  logic              buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d;
  logic [DATA_W-1:0] rdata_buf_q, rdata_buf_d;
  logic              is_load_q, is_load_d;
  logic              gr_we_q, gr_we_d;
  logic [4:0]        dest_q, dest_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [31:0]       pc_q, pc_d;
  logic [1:0]        ld_width_q, ld_width_d;
  logic              ld_sign_q, ld_sign_d;
  logic [1:0]        ld_lr_q, ld_lr_d;
  logic [OFF_W-1:0]  ld_off_q, ld_off_d;

  logic              data_hit;
  logic              ms_ready_go;
  logic              accept;
  logic              leave;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [DATA_W-1:0] rdata_src;
  logic [1:0]        align_lr;
  logic [DATA_W-1:0] ld_result;
  logic [BE_W-1:0]   we_raw;

  always_comb begin
    // a response only belongs to the resident load once all stale ones are gone
    data_hit    = data_sram_data_ok && (discard_cnt_q == '0);
    ms_ready_go = !is_load_q || buf_valid_q || data_hit;
    ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    accept      = es_to_ms_valid && ms_allowin;
    leave       = ms_valid_q && ms_ready_go && ws_allowin;
    cnt_inc     = flush && ms_valid_q && is_load_q && !ms_ready_go;
    cnt_dec     = data_sram_data_ok && (discard_cnt_q != '0);

    ms_valid_d = ms_valid_q;
    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;

    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    if (flush || leave) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && is_load_q && !buf_valid_q && data_hit) begin
      buf_valid_d = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end

    discard_cnt_d = discard_cnt_q;
    if (cnt_inc && !cnt_dec) begin
      if (discard_cnt_q != CNT_W'(MAX_OUTST)) discard_cnt_d = discard_cnt_q + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end

    is_load_d    = accept ? es_is_load    : is_load_q;
    gr_we_d      = accept ? es_gr_we      : gr_we_q;
    dest_d       = accept ? es_dest       : dest_q;
    alu_result_d = accept ? es_alu_result : alu_result_q;
    pc_d         = accept ? es_pc         : pc_q;
    ld_width_d   = accept ? es_ld_width   : ld_width_q;
    ld_sign_d    = accept ? es_ld_sign    : ld_sign_q;
    ld_lr_d      = accept ? es_ld_lr      : ld_lr_q;
    ld_off_d     = accept ? es_ld_off     : ld_off_q;

    rdata_src = buf_valid_q ? rdata_buf_q : data_sram_rdata;
    align_lr  = is_load_q ? ld_lr_q : 2'b00;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rdata_buf_q  <= rdata_buf_d;
    is_load_q    <= is_load_d;
    gr_we_q      <= gr_we_d;
    dest_q       <= dest_d;
    alu_result_q <= alu_result_d;
    pc_q         <= pc_d;
    ld_width_q   <= ld_width_d;
    ld_sign_q    <= ld_sign_d;
    ld_lr_q      <= ld_lr_d;
    ld_off_q     <= ld_off_d;
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata     (rdata_src),
    .ld_width  (ld_width_q),
    .ld_sign   (ld_sign_q),
    .ld_lr     (align_lr),
    .ld_off    (ld_off_q),
    .gr_we     (gr_we_q),
    .ld_result (ld_result),
    .reg_we    (we_raw)
  );

  assign ms_to_ws_valid  = ms_valid_q && ms_ready_go;
  assign ms_load_wait    = ms_valid_q && is_load_q && !ms_ready_go;
  assign ms_reg_we       = ms_valid_q ? we_raw : '0;
  assign ms_final_result = is_load_q ? ld_result : alu_result_q;
  assign ms_dest         = dest_q;
  assign ms_pc           = pc_q;

  a_discard_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(cnt_inc && !cnt_dec && discard_cnt_q == CNT_W'(MAX_OUTST)));

endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: directed scenarios plus a randomized stream
// scored against a byte-level load model and an in-order expectation queue.
module tb_mem_resp_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid, ms_allowin, es_is_load, es_gr_we, es_ld_sign;
  logic [4:0]  es_dest, ms_dest;
  logic [31:0] es_alu_result, es_pc, data_sram_rdata, ms_final_result, ms_pc;
  logic [1:0]  es_ld_width, es_ld_lr, es_ld_off;
  logic        data_sram_data_ok, flush, ws_allowin, ms_to_ws_valid, ms_load_wait;
  logic [3:0]  ms_reg_we;

  logic        w_es_to_ms_valid, w_ms_allowin, w_es_is_load, w_es_gr_we, w_es_ld_sign;
  logic [4:0]  w_es_dest, w_ms_dest;
  logic [63:0] w_es_alu_result, w_data_sram_rdata, w_ms_final_result;
  logic [31:0] w_es_pc, w_ms_pc;
  logic [1:0]  w_es_ld_width, w_es_ld_lr;
  logic [2:0]  w_es_ld_off;
  logic        w_data_sram_data_ok, w_flush, w_ws_allowin, w_ms_to_ws_valid, w_ms_load_wait;
  logic [7:0]  w_ms_reg_we;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] res;
    logic [3:0]  we;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] resp_q[$];

  always #5 clk = ~clk;

  mem_resp_stage dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_is_load(es_is_load), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_alu_result(es_alu_result), .es_pc(es_pc), .es_ld_width(es_ld_width),
    .es_ld_sign(es_ld_sign), .es_ld_lr(es_ld_lr), .es_ld_off(es_ld_off),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_reg_we(ms_reg_we), .ms_dest(ms_dest), .ms_final_result(ms_final_result),
    .ms_pc(ms_pc), .ms_load_wait(ms_load_wait)
  );

  mem_resp_stage #(.DATA_W(64), .MAX_OUTST(2)) dut64 (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(w_es_to_ms_valid), .ms_allowin(w_ms_allowin),
    .es_is_load(w_es_is_load), .es_gr_we(w_es_gr_we), .es_dest(w_es_dest),
    .es_alu_result(w_es_alu_result), .es_pc(w_es_pc), .es_ld_width(w_es_ld_width),
    .es_ld_sign(w_es_ld_sign), .es_ld_lr(w_es_ld_lr), .es_ld_off(w_es_ld_off),
    .data_sram_data_ok(w_data_sram_data_ok), .data_sram_rdata(w_data_sram_rdata),
    .flush(w_flush), .ws_allowin(w_ws_allowin), .ms_to_ws_valid(w_ms_to_ws_valid),
    .ms_reg_we(w_ms_reg_we), .ms_dest(w_ms_dest), .ms_final_result(w_ms_final_result),
    .ms_pc(w_ms_pc), .ms_load_wait(w_ms_load_wait)
  );

  // Byte-array view of a load: n bytes per word, little-endian lanes.
  function automatic logic [63:0] model_result(input logic [63:0] rd, input int n,
      input logic [1:0] width, input logic sign, input logic [1:0] lr, input int off);
    logic [7:0]  b[8];
    logic [63:0] r;
    int start, nb;
    for (int k = 0; k < 8; k++) b[k] = rd[8*k +: 8];
    r = '0;
    if (lr[1]) begin
      for (int j = 0; j < n; j++) r[8*(n-1-j) +: 8] = b[(off - j + n) % n];
    end else if (lr[0]) begin
      for (int j = 0; j < n; j++) r[8*j +: 8] = b[(off + j) % n];
    end else begin
      case (width)
        2'b01:   begin start = off;           nb = 1; end
        2'b10:   begin start = (off / 2) * 2; nb = 2; end
        2'b11:   begin start = (off / 4) * 4; nb = 4; end
        default: begin start = 0;             nb = n; end
      endcase
      for (int k = 0; k < nb; k++) r[8*k +: 8] = b[start + k];
      if (sign && nb < n && b[start + nb - 1][7])
        for (int k = nb; k < n; k++) r[8*k +: 8] = 8'hFF;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_we(input int n, input logic gr_we,
      input logic [1:0] lr, input int off);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < n; k++) begin
      if (lr[1])      m[k] = (k >= n - 1 - off);
      else if (lr[0]) m[k] = (k <= n - 1 - off);
      else            m[k] = 1'b1;
    end
    return gr_we ? m : 8'h00;
  endfunction

  task automatic offer(input logic ld, input logic [1:0] wd, input logic sg,
      input logic [1:0] lr, input logic [1:0] off, input logic [31:0] alu,
      input logic [31:0] pc, input logic [4:0] dst);
    es_is_load = ld; es_gr_we = 1'b1; es_ld_width = wd; es_ld_sign = sg;
    es_ld_lr = lr; es_ld_off = off; es_alu_result = alu; es_pc = pc; es_dest = dst;
    es_to_ms_valid = 1'b1;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_load_wait !== 1'b0 || ms_reg_we !== 4'h0 || ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b wait=%b we=%b allowin=%b, want 0 0 0000 1",
               ms_to_ws_valid, ms_load_wait, ms_reg_we, ms_allowin);
    end
    @(posedge clk); #1 resetn = 1'b1;
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h100, 5'd3);
    @(negedge clk);
    checks++;
    if (ms_load_wait !== 1'b1) begin
      errors++; $display("FAIL reset_preload_wait: wait=%b, want 1", ms_load_wait);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_load_wait !== 1'b0 || ms_reg_we !== 4'h0 || ms_allowin !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: valid=%b wait=%b we=%b allowin=%b, want 0 0 0000 1",
               ms_to_ws_valid, ms_load_wait, ms_reg_we, ms_allowin);
    end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_lb_sign();
    offer(1'b1, 2'b01, 1'b1, 2'b00, 2'd3, 32'h3, 32'h200, 5'd7);
    @(negedge clk);
    checks++;
    if (ms_load_wait !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
      errors++; $display("FAIL lb_wait: wait=%b valid=%b, want 1 0", ms_load_wait, ms_to_ws_valid);
    end
    #1 data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'hFFFF_FF80 || ms_reg_we !== 4'b1111 || ms_dest !== 5'd7) begin
      errors++;
      $display("FAIL lb_result: valid=%b res=%h we=%b dest=%0d, want 1 ffffff80 1111 7",
               ms_to_ws_valid, ms_final_result, ms_reg_we, ms_dest);
    end
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin
      errors++; $display("FAIL lb_left: valid=%b, want 0", ms_to_ws_valid);
    end
  endtask

  task automatic test_lwl();
    offer(1'b1, 2'b11, 1'b0, 2'b10, 2'd1, 32'h1, 32'h204, 5'd8);
    #1 data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4433_2211;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_reg_we !== 4'b1100 || ms_final_result[31:16] !== 16'h2211) begin
      errors++;
      $display("FAIL lwl: valid=%b we=%b res_hi=%h, want 1 1100 2211",
               ms_to_ws_valid, ms_reg_we, ms_final_result[31:16]);
    end
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
  endtask

  task automatic test_hold_buffer();
    logic [31:0] r;
    int deliv;
    r = $urandom;
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h300, 5'd9);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = r;
    @(posedge clk); #1 data_sram_data_ok = 1'b0; data_sram_rdata = ~r;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ms_to_ws_valid !== 1'b1 || ms_final_result !== r || ms_allowin !== 1'b0 || ms_load_wait !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b res=%h allowin=%b wait=%b, want 1 %h 0 0",
                 c, ms_to_ws_valid, ms_final_result, ms_allowin, ms_load_wait, r);
      end
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    deliv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) begin
        deliv++;
        checks++;
        if (ms_final_result !== r) begin
          errors++; $display("FAIL hold_deliver: res=%h, want %h", ms_final_result, r);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (deliv != 1) begin
      errors++; $display("FAIL hold_once: deliveries=%0d, want 1", deliv);
    end
  endtask

  task automatic test_flush_waiting();
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h400, 5'd4);
    @(negedge clk);
    checks++;
    if (ms_load_wait !== 1'b1) begin
      errors++; $display("FAIL flushw_wait: wait=%b, want 1", ms_load_wait);
    end
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || dut.discard_cnt_q !== 2'd1) begin
      errors++;
      $display("FAIL flushw_after: valid=%b allowin=%b cnt=%0d, want 0 1 1",
               ms_to_ws_valid, ms_allowin, dut.discard_cnt_q);
    end
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h404, 5'd9);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b0 || ms_load_wait !== 1'b1) begin
      errors++; $display("FAIL flushw_drop: valid=%b wait=%b, want 0 1", ms_to_ws_valid, ms_load_wait);
    end
    @(posedge clk); #1 data_sram_rdata = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (dut.discard_cnt_q !== 2'd0 || ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h1234 || ms_dest !== 5'd9) begin
      errors++;
      $display("FAIL flushw_new: cnt=%0d valid=%b res=%h dest=%0d, want 0 1 00001234 9",
               dut.discard_cnt_q, ms_to_ws_valid, ms_final_result, ms_dest);
    end
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_coincide();
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h500, 5'd5);
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_AAAA;
    @(posedge clk); #1 flush = 1'b0; data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.discard_cnt_q !== 2'd0 || ms_to_ws_valid !== 1'b0) begin
      errors++;
      $display("FAIL coincide_cnt: cnt=%0d valid=%b, want 0 0", dut.discard_cnt_q, ms_to_ws_valid);
    end
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h504, 5'd10);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_5555;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h5555 || ms_dest !== 5'd10) begin
      errors++;
      $display("FAIL coincide_next: valid=%b res=%h dest=%0d, want 1 00005555 10",
               ms_to_ws_valid, ms_final_result, ms_dest);
    end
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
  endtask

  // Stale response arriving in the same cycle as a new flush keeps the count.
  task automatic test_inc_dec_coincide();
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h600, 5'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h604, 5'd2);
    flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    @(posedge clk); #1 flush = 1'b0; data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.discard_cnt_q !== 2'd1) begin
      errors++; $display("FAIL incdec_cnt: cnt=%0d, want 1", dut.discard_cnt_q);
    end
    offer(1'b1, 2'b11, 1'b0, 2'b00, 2'd0, 32'h0, 32'h608, 5'd3);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
    @(posedge clk); #1 data_sram_rdata = 32'h3333_3333;
    @(negedge clk);
    checks++;
    if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h3333_3333 || ms_dest !== 5'd3) begin
      errors++;
      $display("FAIL incdec_next: valid=%b res=%h dest=%0d, want 1 33333333 3",
               ms_to_ws_valid, ms_final_result, ms_dest);
    end
    @(posedge clk); #1 data_sram_data_ok = 1'b0;
  endtask

  task automatic test_dw64();
    logic [63:0] rd, exp_r;
    logic [7:0]  exp_w;
    logic [1:0]  wd, lr;
    logic        sg;
    logic [2:0]  off;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        wd = 2'b10; sg = 1'b0; lr = 2'b00; off = 3'd6; rd = 64'h8001_1234_5678_9ABC;
      end else begin
        wd = 2'($urandom_range(0, 3)); sg = 1'($urandom); off = 3'($urandom);
        case ($urandom_range(0, 3))
          2: lr = 2'b10;
          3: lr = 2'b01;
          default: lr = 2'b00;
        endcase
        rd = {$urandom, $urandom};
      end
      exp_r = model_result(rd, 8, wd, sg, lr, int'(off));
      exp_w = model_we(8, 1'b1, lr, int'(off));
      if (i == 0 && exp_r !== 64'h8001) begin
        errors++; $display("FAIL dw64_model_lh: model=%h, want 0000000000008001", exp_r);
      end
      w_es_is_load = 1'b1; w_es_gr_we = 1'b1; w_es_ld_width = wd; w_es_ld_sign = sg;
      w_es_ld_lr = lr; w_es_ld_off = off; w_es_alu_result = 64'(off); w_es_pc = 32'h700 + 32'(i);
      w_es_dest = 5'(i); w_es_to_ms_valid = 1'b1;
      @(posedge clk); #1 w_es_to_ms_valid = 1'b0;
      w_data_sram_data_ok = 1'b1; w_data_sram_rdata = rd;
      @(negedge clk);
      checks++;
      if (w_ms_to_ws_valid !== 1'b1 || w_ms_final_result !== exp_r || w_ms_reg_we !== exp_w) begin
        errors++;
        $display("FAIL dw64_load%0d: valid=%b res=%h we=%b, want 1 %h %b (w=%b lr=%b off=%0d s=%b)",
                 i, w_ms_to_ws_valid, w_ms_final_result, w_ms_reg_we, exp_r, exp_w, wd, lr, off, sg);
      end
      @(posedge clk); #1 w_data_sram_data_ok = 1'b0;
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] pend_rd;
    logic [63:0] m;
    exp_t        e, got;
    int          drained;
    bit          accepted;
    pend_rd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit stop_offers;
      stop_offers = (cyc >= 560);
      ws_allowin = stop_offers ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (resp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        data_sram_data_ok = 1'b1; data_sram_rdata = resp_q[0];
      end else begin
        data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
      end
      if (!es_to_ms_valid && !stop_offers && $urandom_range(0, 2) != 0) begin
        es_is_load = 1'($urandom); es_dest = 5'($urandom); es_pc = $urandom;
        es_alu_result = $urandom; es_ld_off = 2'($urandom); es_ld_sign = 1'($urandom);
        es_ld_width = 2'($urandom_range(1, 3));
        if (es_is_load) begin
          es_gr_we = 1'b1;
          case ($urandom_range(0, 3))
            2: es_ld_lr = 2'b10;
            3: es_ld_lr = 2'b01;
            default: es_ld_lr = 2'b00;
          endcase
        end else begin
          es_gr_we = 1'($urandom); es_ld_lr = 2'b00;
        end
        pend_rd = $urandom;
        es_to_ms_valid = 1'b1;
      end
      @(negedge clk);
      if (ms_to_ws_valid && ws_allowin) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected result res=%h dest=%0d", ms_final_result, ms_dest);
        end else begin
          e = exp_q.pop_front();
          got.dest = ms_dest; got.pc = ms_pc; got.res = ms_final_result; got.we = ms_reg_we;
          if (got.dest !== e.dest || got.pc !== e.pc || got.res !== e.res || got.we !== e.we) begin
            errors++;
            $display("FAIL stream_out: dest=%0d pc=%h res=%h we=%b, want %0d %h %h %b",
                     got.dest, got.pc, got.res, got.we, e.dest, e.pc, e.res, e.we);
          end
        end
      end
      if (data_sram_data_ok) void'(resp_q.pop_front());
      accepted = es_to_ms_valid && ms_allowin;
      if (accepted) begin
        e.dest = es_dest; e.pc = es_pc;
        if (es_is_load) begin
          m = model_result({32'h0, pend_rd}, 4, es_ld_width, es_ld_sign, es_ld_lr, int'(es_ld_off));
          e.res = m[31:0];
          e.we  = 4'(model_we(4, es_gr_we, es_ld_lr, int'(es_ld_off)));
          resp_q.push_back(pend_rd);
        end else begin
          e.res = es_alu_result;
          e.we  = es_gr_we ? 4'hF : 4'h0;
        end
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (accepted) es_to_ms_valid = 1'b0;
    end
    data_sram_data_ok = 1'b0;
    drained = exp_q.size();
    checks++;
    if (drained != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: %0d results and %0d responses left, want 0 0", drained, resp_q.size());
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0; es_is_load = 1'b0; es_gr_we = 1'b0; es_dest = '0;
    es_alu_result = '0; es_pc = '0; es_ld_width = '0; es_ld_sign = 1'b0; es_ld_lr = '0; es_ld_off = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    w_flush = 1'b0; w_ws_allowin = 1'b1;
    w_es_to_ms_valid = 1'b0; w_es_is_load = 1'b0; w_es_gr_we = 1'b0; w_es_dest = '0;
    w_es_alu_result = '0; w_es_pc = '0; w_es_ld_width = '0; w_es_ld_sign = 1'b0; w_es_ld_lr = '0;
    w_es_ld_off = '0; w_data_sram_data_ok = 1'b0; w_data_sram_rdata = '0;

    test_reset();
    test_lb_sign();
    test_lwl();
    test_hold_buffer();
    test_flush_waiting();
    test_flush_coincide();
    test_inc_dec_coincide();
    test_dw64();
    test_random_stream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
